// File: rtl/uart_param_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_param_if
// Description : Host-side bundle of the parametrised UART core: tick divisor,
//               parity select, TX valid/ready, serial lines and RX result.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_param_if #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
);
    logic [DIV_W-1:0]  divisor;
    logic              parity_odd;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              serial_out;
    logic              serial_in;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_frame_err;
    logic              rx_parity_err;

    modport master (
        output divisor, parity_odd, tx_data, tx_valid, serial_in,
        input  tx_ready, serial_out, rx_data, rx_valid, rx_frame_err, rx_parity_err
    );

    modport slave (
        input  divisor, parity_odd, tx_data, tx_valid, serial_in,
        output tx_ready, serial_out, rx_data, rx_valid, rx_frame_err, rx_parity_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_param
// Description : Single-clock UART: shared 16x tick generator, TX and RX FSMs.
//               Optional parity bit compiled in with macro UART_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_param #(
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_param_if.slave   bus
);

    localparam logic [2:0]       c_st_idle   = 3'd0;
    localparam logic [2:0]       c_st_start  = 3'd1;
    localparam logic [2:0]       c_st_data   = 3'd2;
    localparam logic [2:0]       c_st_parity = 3'd3;
    localparam logic [2:0]       c_st_stop   = 3'd4;
    localparam logic [3:0]       c_phase_mid  = 4'd7;
    localparam logic [3:0]       c_phase_last = 4'd15;
    localparam logic [3:0]       c_data_last  = 4'(DATA_W - 1);
    localparam logic [3:0]       c_stop_last  = 4'(STOP_BITS - 1);
    localparam logic [DIV_W-1:0] c_div_one    = DIV_W'(1);

    // ------------------------------------------------------------------ tick
    logic [DIV_W-1:0] r_tick_cnt;
    logic [DIV_W-1:0] w_div_m1;
    logic             w_tick;
    logic             w_rx_start;

    // >= rather than == so a shrinking divisor can never let the count run away
    assign w_div_m1 = (bus.divisor == '0) ? '0 : (bus.divisor - c_div_one);
    assign w_tick   = (r_tick_cnt >= w_div_m1);

    always_ff @(posedge clk) begin
        if (!rst_n || w_rx_start) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_div_one;
        end
    end

    // -------------------------------------------------------------------- TX
    logic [2:0]        r_tx_state;
    logic [2:0]        w_tx_state_nxt;
    logic [3:0]        r_tx_phase;
    logic [3:0]        r_tx_bits;
    logic [DATA_W-1:0] r_tx_shift;
    logic              r_tx_ready;
    logic              r_serial_out;
    logic              w_tx_line;
    logic              w_tx_accept;
    logic              w_tx_bit_end;
`ifdef UART_PARITY_EN
    logic              r_tx_par;
`endif

    assign w_tx_accept  = bus.tx_valid & r_tx_ready;
    assign w_tx_bit_end = w_tick & (r_tx_phase == c_phase_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_state <= c_st_idle;
        end else begin
            r_tx_state <= w_tx_state_nxt;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        case (r_tx_state)
            c_st_idle:   if (w_tx_accept) w_tx_state_nxt = c_st_start;
            c_st_start:  if (w_tx_bit_end) w_tx_state_nxt = c_st_data;
            c_st_data: begin
                if (w_tx_bit_end && (r_tx_bits == c_data_last)) begin
`ifdef UART_PARITY_EN
                    w_tx_state_nxt = c_st_parity;
`else
                    w_tx_state_nxt = c_st_stop;
`endif
                end
            end
            c_st_parity: if (w_tx_bit_end) w_tx_state_nxt = c_st_stop;
            c_st_stop: begin
                if (w_tx_bit_end && (r_tx_bits == c_stop_last)) begin
                    w_tx_state_nxt = c_st_idle;
                end
            end
            default:     w_tx_state_nxt = c_st_idle;
        endcase
    end

    // Line level for the next cycle; serial_out registers it
    always_comb begin
        w_tx_line = 1'b1;
        case (w_tx_state_nxt)
            c_st_start:  w_tx_line = 1'b0;
            c_st_data:   w_tx_line = ((r_tx_state == c_st_data) && w_tx_bit_end) ?
                                     r_tx_shift[1] : r_tx_shift[0];
`ifdef UART_PARITY_EN
            c_st_parity: w_tx_line = r_tx_par;
`endif
            default:     w_tx_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_phase   <= '0;
            r_tx_bits    <= '0;
            r_tx_shift   <= '0;
            r_tx_ready   <= 1'b1;
            r_serial_out <= 1'b1;
`ifdef UART_PARITY_EN
            r_tx_par     <= 1'b0;
`endif
        end else begin
            r_tx_ready   <= (w_tx_state_nxt == c_st_idle);
            r_serial_out <= w_tx_line;
            if (r_tx_state == c_st_idle) begin
                r_tx_phase <= '0;
            end else if (w_tick) begin
                r_tx_phase <= r_tx_phase + 4'd1;
            end
            if (r_tx_state == c_st_idle) begin
                r_tx_bits <= '0;
            end else if (w_tx_bit_end) begin
                r_tx_bits <= (w_tx_state_nxt != r_tx_state) ? 4'd0 : (r_tx_bits + 4'd1);
            end
            if (w_tx_accept) begin
                r_tx_shift <= bus.tx_data;
            end else if ((r_tx_state == c_st_data) && w_tx_bit_end) begin
                r_tx_shift <= {1'b0, r_tx_shift[DATA_W-1:1]};
            end
`ifdef UART_PARITY_EN
            if (w_tx_accept) begin
                r_tx_par <= (^bus.tx_data) ^ bus.parity_odd;
            end
`endif
        end
    end

    assign bus.tx_ready   = r_tx_ready;
    assign bus.serial_out = r_serial_out;

    // -------------------------------------------------------------------- RX
    logic [2:0]        r_rx_state;
    logic [2:0]        w_rx_state_nxt;
    logic              r_rx_meta;
    logic              r_rx_line;
    logic [3:0]        r_rx_phase;
    logic [3:0]        r_rx_bits;
    logic [DATA_W-1:0] r_rx_shift;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_rx_ferr;
    logic              w_rx_mid;
    logic              w_rx_sample;
    logic              w_rx_shift_en;
    logic              w_rx_done;
`ifdef UART_PARITY_EN
    logic              r_rx_par;
    logic              r_rx_perr;
    logic              w_rx_par_en;
`endif

    assign w_rx_start  = (r_rx_state == c_st_idle) & ~r_rx_line;
    assign w_rx_mid    = w_tick & (r_rx_phase == c_phase_mid);
    assign w_rx_sample = w_tick & (r_rx_phase == c_phase_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_state <= c_st_idle;
        end else begin
            r_rx_state <= w_rx_state_nxt;
        end
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        case (r_rx_state)
            c_st_idle:   if (!r_rx_line) w_rx_state_nxt = c_st_start;
            c_st_start:  if (w_rx_mid) w_rx_state_nxt = r_rx_line ? c_st_idle : c_st_data;
            c_st_data: begin
                if (w_rx_sample && (r_rx_bits == c_data_last)) begin
`ifdef UART_PARITY_EN
                    w_rx_state_nxt = c_st_parity;
`else
                    w_rx_state_nxt = c_st_stop;
`endif
                end
            end
            c_st_parity: if (w_rx_sample) w_rx_state_nxt = c_st_stop;
            c_st_stop:   if (w_rx_sample) w_rx_state_nxt = c_st_idle;
            default:     w_rx_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        w_rx_shift_en = (r_rx_state == c_st_data) & w_rx_sample;
        w_rx_done     = (r_rx_state == c_st_stop) & w_rx_sample;
`ifdef UART_PARITY_EN
        w_rx_par_en   = (r_rx_state == c_st_parity) & w_rx_sample;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_meta  <= 1'b1;
            r_rx_line  <= 1'b1;
            r_rx_phase <= '0;
            r_rx_bits  <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
`ifdef UART_PARITY_EN
            r_rx_par   <= 1'b0;
            r_rx_perr  <= 1'b0;
`endif
        end else begin
            r_rx_meta  <= bus.serial_in;
            r_rx_line  <= r_rx_meta;
            r_rx_valid <= w_rx_done;
            // Phase restarts at the start-bit centre so data samples land mid-bit
            if ((r_rx_state == c_st_idle) || ((r_rx_state == c_st_start) && w_rx_mid)) begin
                r_rx_phase <= '0;
            end else if (w_tick) begin
                r_rx_phase <= r_rx_phase + 4'd1;
            end
            if (r_rx_state != c_st_data) begin
                r_rx_bits <= '0;
            end else if (w_rx_sample) begin
                r_rx_bits <= r_rx_bits + 4'd1;
            end
            if (w_rx_shift_en) begin
                r_rx_shift <= {r_rx_line, r_rx_shift[DATA_W-1:1]};
            end
`ifdef UART_PARITY_EN
            if (w_rx_par_en) begin
                r_rx_par <= r_rx_line;
            end
            if (w_rx_done) begin
                r_rx_perr <= r_rx_par ^ (^r_rx_shift) ^ bus.parity_odd;
            end
`endif
            if (w_rx_done) begin
                r_rx_data <= r_rx_shift;
                r_rx_ferr <= ~r_rx_line;
            end
        end
    end

    assign bus.rx_data      = r_rx_data;
    assign bus.rx_valid     = r_rx_valid;
    assign bus.rx_frame_err = r_rx_ferr;
`ifdef UART_PARITY_EN
    assign bus.rx_parity_err = r_rx_perr;
`else
    logic w_unused_parity;
    assign w_unused_parity   = bus.parity_odd;
    assign bus.rx_parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_param
// Description : Self-checking bench for uart_param: queue-based frame model,
//               per-cycle compare process, directed and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_param;

    localparam int DATA_W    = 8;
    localparam int STOP_BITS = 1;
    localparam int DIV_W     = 16;
`ifdef UART_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME = (1 + DATA_W + P + STOP_BITS) * 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic loop  = 1'b0;
    logic drv   = 1'b1;
    bit   chk_tx = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int rx_count = 0;

    bit         tx_q[$];
    logic [9:0] rx_q[$];          // {parity_err, frame_err, data}
    logic [9:0] last_res = '0;
    bit         prev_valid = 1'b0;

    uart_param_if #(.DATA_W(DATA_W), .DIV_W(DIV_W)) bus ();

    uart_param #(
        .DATA_W    (DATA_W),
        .STOP_BITS (STOP_BITS),
        .DIV_W     (DIV_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.serial_in = loop ? bus.serial_out : drv;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected serial_out, one entry per cycle at a tick every cycle
    task automatic push_frame(input logic [7:0] d, input logic po);
        repeat (16) tx_q.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) repeat (16) tx_q.push_back(d[i]);
        if (P != 0) repeat (16) tx_q.push_back((^d) ^ po);
        repeat (16 * STOP_BITS) tx_q.push_back(1'b1);
    endtask

    always @(negedge clk) begin
        logic [9:0] e;
        bit         b;
        if (!rst_n) begin
            tx_q.delete();
            rx_q.delete();
            last_res   = '0;
            prev_valid = 1'b0;
        end else begin
            if (chk_tx) begin
                if (tx_q.size() > 0) begin
                    b = tx_q.pop_front();
                    chk("tx_line", 32'(bus.serial_out), 32'(b));
                    chk("tx_ready_busy", 32'(bus.tx_ready), 32'd0);
                end else begin
                    chk("tx_line_idle", 32'(bus.serial_out), 32'd1);
                    chk("tx_ready_idle", 32'(bus.tx_ready), 32'd1);
                end
                if (bus.tx_valid && bus.tx_ready) begin
                    push_frame(bus.tx_data, bus.parity_odd);
                    if (loop) rx_q.push_back({2'b00, bus.tx_data});
                end
            end
            if (bus.rx_valid) begin
                rx_count++;
                chk("rx_valid_pulse", 32'(prev_valid), 32'd0);
                if (rx_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rx_unexpected: rx_valid with data 0x%0h, expected no word", bus.rx_data);
                    last_res = {bus.rx_parity_err, bus.rx_frame_err, bus.rx_data};
                end else begin
                    e = rx_q.pop_front();
                    chk("rx_data", 32'(bus.rx_data), 32'(e[7:0]));
                    chk("rx_frame_err", 32'(bus.rx_frame_err), 32'(e[8]));
                    chk("rx_parity_err", 32'(bus.rx_parity_err), 32'(e[9]));
                    last_res = e;
                end
            end else begin
                chk("rx_hold", 32'({bus.rx_parity_err, bus.rx_frame_err, bus.rx_data}), 32'(last_res));
            end
            prev_valid = bus.rx_valid;
        end
    end

    task automatic tx_send(input logic [7:0] d, input bit hold);
        int n = 0;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        while (!bus.tx_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.tx_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL tx_accept_timeout: tx_ready 0 after %0d cycles, expected 1", n);
        end
        @(posedge clk);
        #1;
        if (!hold) bus.tx_valid = 1'b0;
    endtask

    task automatic wait_tx_idle();
        int n = 0;
        @(negedge clk);
        while (!bus.tx_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("tx_idle_timeout", 32'(bus.tx_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic rx_send(input logic [7:0] d, input bit stop_lvl, input bit flip);
        bit f;
        f = (P != 0) ? flip : 1'b0;
        rx_q.push_back({f, ~stop_lvl, d});
        drv = 1'b0;
        step(16);
        for (int i = 0; i < DATA_W; i++) begin
            drv = d[i];
            step(16);
        end
        if (P != 0) begin
            drv = (^d) ^ bus.parity_odd ^ f;
            step(16);
        end
        drv = stop_lvl;
        step(16);
        drv = 1'b1;
        step(24);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        int run;
        bit seen_high;
        bit run_done;
        int cnt0;
        logic [9:0] a5_exp;
        logic [7:0] d0;
        logic [7:0] d1;

        bus.divisor    = 16'd1;
        bus.parity_odd = 1'b0;
        bus.tx_data    = '0;
        bus.tx_valid   = 1'b0;
        step(3);
        @(negedge clk);
        chk("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        chk("rst_serial_out", 32'(bus.serial_out), 32'd1);
        chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
        chk("rst_rx_frame_err", 32'(bus.rx_frame_err), 32'd0);
        chk("rst_rx_parity_err", 32'(bus.rx_parity_err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4);

        // TX 0xA5: mid-bit levels and busy length against hand values
        a5_exp = 10'b11_0100_1010;
        tx_send(8'hA5, 1'b0);
        low = 0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if ((n % 16 == 8) && (n / 16 < 9)) chk("a5_level", 32'(bus.serial_out), 32'(a5_exp[n / 16]));
            if (bus.tx_ready) break;
            low++;
        end
        chk("a5_busy_cycles", 32'(low), 32'(160 + 16 * P));
        step(10);

        // Loopback single then back-to-back
        loop = 1'b1;
        bus.parity_odd = 1'b1;
        tx_send(8'h3C, 1'b0);
        wait_tx_idle();
        step(30);
        chk("loop_3c_data", 32'(bus.rx_data), 32'h3C);
        cnt0 = rx_count;
        tx_send(8'h3C, 1'b1);
        tx_send(8'hFF, 1'b0);
        wait_tx_idle();
        step(30);
        chk("loop_b2b_pulses", 32'(rx_count - cnt0), 32'd2);
        chk("loop_ff_data", 32'(bus.rx_data), 32'hFF);
        loop = 1'b0;
        step(10);

        // Stop bit held low
        rx_send(8'h55, 1'b0, 1'b0);
        chk("ferr_data", 32'(bus.rx_data), 32'h55);
        chk("ferr_flag", 32'(bus.rx_frame_err), 32'd1);

        // Flipped parity bit
        if (P != 0) begin
            rx_send(8'h01, 1'b1, 1'b1);
            chk("perr_data", 32'(bus.rx_data), 32'h01);
            chk("perr_flag", 32'(bus.rx_parity_err), 32'd1);
        end

        // Short low glitch must not produce a word
        cnt0 = rx_count;
        drv = 1'b0;
        step(4);
        drv = 1'b1;
        step(40);
        chk("glitch_no_word", 32'(rx_count - cnt0), 32'd0);
        rx_send(8'h81, 1'b1, 1'b0);
        chk("after_glitch_data", 32'(bus.rx_data), 32'h81);
        chk("after_glitch_ferr", 32'(bus.rx_frame_err), 32'd0);

        // Reset mid-frame in both directions
        loop = 1'b1;
        cnt0 = rx_count;
        tx_send(8'h5A, 1'b0);
        step(50);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_serial_out", 32'(bus.serial_out), 32'd1);
        chk("midrst_tx_ready", 32'(bus.tx_ready), 32'd1);
        step(300);
        chk("midrst_no_word", 32'(rx_count - cnt0), 32'd0);
        loop = 1'b0;

        // Divisor 10: frame span and one exact data-bit width
        chk_tx = 1'b0;
        bus.divisor = 16'd10;
        tx_send(8'hA5, 1'b0);
        low = 0;
        run = 0;
        seen_high = 1'b0;
        run_done = 1'b0;
        for (int n = 0; n < 5000; n++) begin
            @(negedge clk);
            if (bus.tx_ready) break;
            low++;
            if (bus.serial_out) seen_high = 1'b1;
            if (seen_high && !run_done) begin
                if (bus.serial_out) run++;
                else run_done = 1'b1;
            end
        end
        n_checks++;
        if (low < FRAME * 10 - 9 || low > FRAME * 10) begin
            n_errors++;
            $display("FAIL div10_span: got %0d cycles, expected %0d..%0d", low, FRAME * 10 - 9, FRAME * 10);
        end
        chk("div10_bit_width", 32'(run), 32'd160);
        bus.divisor = 16'd1;
        step(5);
        chk_tx = 1'b1;
        step(2);

        // Random traffic at divisor 0 or 1
        for (int it = 0; it < 24; it++) begin
            bus.divisor    = 16'($urandom_range(0, 1));
            bus.parity_odd = 1'($urandom_range(0, 1));
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            case ($urandom_range(0, 2))
                0: begin
                    loop = 1'b1;
                    tx_send(d0, 1'b0);
                    wait_tx_idle();
                    step(30);
                    loop = 1'b0;
                end
                1: begin
                    loop = 1'b1;
                    tx_send(d0, 1'b1);
                    tx_send(d1, 1'b0);
                    wait_tx_idle();
                    step(30);
                    loop = 1'b0;
                end
                default: begin
                    rx_send(d0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
                end
            endcase
            step($urandom_range(2, 20));
        end

        step(20);
        chk("rx_pending", 32'(rx_q.size()), 32'd0);
        chk("tx_pending", 32'(tx_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
